alu_mult_seq: RTL and testbench



---
 rtl/alu_mult_seq.sv | 111 +++++++++++
 tb/tb_alu_mult_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_seq.sv
// Sequential shift-add unsigned multiplier for the miniMIPS ALU mult op.
// Define MULT_EARLY_TERM_EN to stop iterating once no multiplier bits remain.
module alu_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, done_q;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] shifted;
  logic               lastStep;

  // The carry out of the hi addition becomes the new top product bit.
  assign sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign shifted  = {sum, lo_q[WIDTH-1:1]};
  assign lastStep = (cnt_q == CNT_W'(WIDTH-1));

`ifdef MULT_EARLY_TERM_EN
  localparam logic [WIDTH-2:0] PEND_MASK = '1;
  logic [WIDTH-2:0]   pendBits;
  logic               earlyStop;
  logic [CNT_W-1:0]   shAmt;

  // Multiplier bits still waiting in lo sit below the product bits already shifted in.
  assign pendBits  = lo_q[WIDTH-1:1] & (PEND_MASK >> cnt_q);
  assign earlyStop = lastStep || (pendBits == '0);
  assign shAmt     = CNT_W'(WIDTH-1) - cnt_q;
`endif

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          mcand_d = a;
          hi_d    = '0;
          lo_d    = b;
          cnt_d   = '0;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
`ifdef MULT_EARLY_TERM_EN
        if (earlyStop) begin
          {hi_d, lo_d} = shifted >> shAmt;
          state_d      = S_DONE;
        end else begin
          {hi_d, lo_d} = shifted;
        end
`else
        {hi_d, lo_d} = shifted;
        if (lastStep) state_d = S_DONE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Randomized and directed bench for alu_mult_seq against an arithmetic reference model.
// Honours MULT_EARLY_TERM_EN for the expected latencies.
module tb_alu_mult_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit checkEn = 1'b0;

  // Reference model state: product from plain multiplication, latency from b.
  logic [2*W-1:0] mProd = '0;
  bit             mBusy = 1'b0;
  bit             mDone = 1'b0;
  bit             mValid = 1'b1;
  int             mRem = 0;

  int             doneQ[$];
  logic [W-1:0]   hiQ[$];
  logic [W-1:0]   loQ[$];
  logic [3:0]     snapOut;
  logic [2*W-1:0] snapProd;

  alu_mult_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic int latency(input logic [W-1:0] bv);
    int l;
`ifdef MULT_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < W; i++) if (bv[i]) l = i + 1;
`else
    l = W;
`endif
    return l;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mBusy = 1'b0; mDone = 1'b0; mProd = '0; mValid = 1'b1; mRem = 0;
    end else if (mBusy) begin
      mRem = mRem - 1;
      if (mRem == 0) begin
        mBusy = 1'b0; mDone = 1'b1; mValid = 1'b1;
      end
    end else begin
      mDone = 1'b0;
      if (start) begin
        mProd  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        mBusy  = 1'b1;
        mRem   = latency(b);
        mValid = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=0x%0h expected=0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Advance to the middle of the next cycle and compare every output against the model.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (checkEn) begin
      checkOutput("busy", {63'b0, busy}, {63'b0, mBusy});
      checkOutput("done", {63'b0, done}, {63'b0, mDone});
      if (mValid) checkOutput("product", {hi, lo}, mProd);
    end
  endtask

  // One operation from cycle 0, optional mid-run start pulse, optional reset, or start held.
  task automatic applyStimulus(input logic [W-1:0] aIn, input logic [W-1:0] bIn,
                               input bit hold, input int pulseCyc,
                               input logic [W-1:0] pa, input logic [W-1:0] pb,
                               input int rstCyc, input int span);
    doneQ.delete(); hiQ.delete(); loQ.delete();
    tick();
    cyc = 0;
    start = 1'b1; a = aIn; b = bIn;
    for (int i = 1; i <= span; i++) begin
      tick();
      if (done === 1'b1) begin
        doneQ.push_back(cyc); hiQ.push_back(hi); loQ.push_back(lo);
      end
      if (cyc == rstCyc + 1) begin
        snapOut  = {busy, done, |hi, |lo};
        snapProd = {hi, lo};
      end
      rst_n = (cyc != rstCyc);
      if (hold) begin
        start = 1'b1;
      end else if (cyc == pulseCyc) begin
        start = 1'b1; a = pa; b = pb;
      end else begin
        start = 1'b0; a = $urandom; b = $urandom;
      end
    end
    start = 1'b0;
    for (int i = 0; i < 3 * W; i++) tick();
  endtask

  initial begin
    int lat;
    $display("[TB] alu_mult_seq bench starting");
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    checkOutput("reset_busy", {63'b0, busy}, 64'd0);
    checkOutput("reset_done", {63'b0, done}, 64'd0);
    checkOutput("reset_prod", {hi, lo}, 64'd0);
    checkEn = 1'b1;

    // 3 * 5
    applyStimulus(32'd3, 32'd5, 1'b0, -1, '0, '0, -1, 40);
`ifdef MULT_EARLY_TERM_EN
    lat = 3;
`else
    lat = 32;
`endif
    checkOutput("3x5_donecount", 64'(doneQ.size()), 64'd1);
    if (doneQ.size() > 0) begin
      checkOutput("3x5_donecyc", 64'(doneQ[0]), 64'(lat + 1));
      checkOutput("3x5_prod", {hiQ[0], loQ[0]}, 64'd15);
    end
    checkOutput("model_3x5", mProd, 64'd15);

    // All-ones operands exercise the carry into the top product bit.
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, '0, '0, -1, 40);
    if (doneQ.size() > 0) begin
      checkOutput("ones_donecyc", 64'(doneQ[0]), 64'd33);
      checkOutput("ones_prod", {hiQ[0], loQ[0]}, 64'hFFFF_FFFE_0000_0001);
    end else checkOutput("ones_donecount", 64'(doneQ.size()), 64'd1);
    checkOutput("model_ones", mProd, 64'hFFFF_FFFE_0000_0001);

    // Zero multiplier, then zero multiplicand.
    applyStimulus(32'h1234_5678, 32'd0, 1'b0, -1, '0, '0, -1, 40);
`ifdef MULT_EARLY_TERM_EN
    lat = 1;
`else
    lat = 32;
`endif
    if (doneQ.size() > 0) begin
      checkOutput("b0_donecyc", 64'(doneQ[0]), 64'(lat + 1));
      checkOutput("b0_prod", {hiQ[0], loQ[0]}, 64'd0);
    end else checkOutput("b0_donecount", 64'(doneQ.size()), 64'd1);
    applyStimulus(32'd0, 32'hDEAD_BEEF, 1'b0, -1, '0, '0, -1, 40);
    if (doneQ.size() > 0) begin
      checkOutput("a0_donecyc", 64'(doneQ[0]), 64'd33);
      checkOutput("a0_prod", {hiQ[0], loQ[0]}, 64'd0);
    end else checkOutput("a0_donecount", 64'(doneQ.size()), 64'd1);

    // 7 * 6 with a 9 * 9 request pulsed in cycle 10.
    applyStimulus(32'd7, 32'd6, 1'b0, 10, 32'd9, 32'd9, -1, 40);
`ifdef MULT_EARLY_TERM_EN
    lat = 3;
`else
    lat = 32;
`endif
    if (doneQ.size() > 0) begin
      checkOutput("busystart_donecyc", 64'(doneQ[0]), 64'(lat + 1));
      checkOutput("busystart_prod", {hiQ[0], loQ[0]}, 64'd42);
    end else checkOutput("busystart_donecount", 64'(doneQ.size()), 64'd1);

    // Start held high gives back-to-back 2 * 3.
    applyStimulus(32'd2, 32'd3, 1'b1, -1, '0, '0, -1, 100);
`ifdef MULT_EARLY_TERM_EN
    lat = 2;
`else
    lat = 32;
`endif
    if (doneQ.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput("held_donecyc", 64'(doneQ[k]), 64'((k + 1) * (lat + 1)));
        checkOutput("held_prod", {hiQ[k], loQ[k]}, 64'd6);
      end
    end else checkOutput("held_donecount", 64'(doneQ.size()), 64'd3);

    // Reset in cycle 15 of 100 * 100, then 4 * 4.
    applyStimulus(32'd100, 32'd100, 1'b0, -1, '0, '0, 15, 60);
    checkOutput("rst_outputs", 64'(snapOut), 64'd0);
    checkOutput("rst_prod", snapProd, 64'd0);
`ifdef MULT_EARLY_TERM_EN
    checkOutput("rst_donecount", 64'(doneQ.size()), 64'd1);
`else
    checkOutput("rst_donecount", 64'(doneQ.size()), 64'd0);
`endif
    applyStimulus(32'd4, 32'd4, 1'b0, -1, '0, '0, -1, 40);
    if (doneQ.size() > 0) checkOutput("4x4_prod", {hiQ[0], loQ[0]}, 64'd16);
    else checkOutput("4x4_donecount", 64'(doneQ.size()), 64'd1);

    // Random traffic; the per-cycle compare in tick() does the checking.
    for (int i = 0; i < 3000; i++) begin
      tick();
      start = ($urandom_range(0, 2) == 0);
      a     = $urandom;
      b     = $urandom >> $urandom_range(0, 31);
      rst_n = ($urandom_range(0, 299) != 0);
    end
    rst_n = 1'b1; start = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
